// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module : reset_sequencer
// Holds all downstream resets until the PLL has been locked long enough, then
// releases them one channel at a time. Re-enters reset on lock loss, a
// debounced button press or a software request, and records the cause.
// Rev    : 1.0
// ============================================================================
module reset_sequencer #(
   parameter int CHANNELS        = 4,
   parameter int HOLD_CYCLES     = 32,
   parameter int STAGE_GAP       = 16,
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pll_locked,
   input  logic                button_n,
   input  logic                sw_req,
   output logic [CHANNELS-1:0] rst_out,
   output logic                done,
   output logic [1:0]          cause,
   output logic [7:0]          reset_count
);

   localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int MAX_CNT = (MAX_HG > DEBOUNCE_CYCLES) ? MAX_HG : DEBOUNCE_CYCLES;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam int SW      = $clog2(CHANNELS + 1);

   localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] GAP_MAX   = CW'(STAGE_GAP);
   localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] LAST_STG  = SW'(CHANNELS - 1);

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_LOCK = 2'b01;
   localparam logic [1:0] CAUSE_BTN  = 2'b10;
   localparam logic [1:0] CAUSE_SW   = 2'b11;

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_RELEASE = 2'd1,
      S_RUN     = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         stage_q, stage_d;
   logic [CHANNELS-1:0]   rst_q, rst_d;
   logic                  done_q, done_d;
   logic [1:0]            cause_q, cause_d;
   logic [7:0]            count_q, count_d;

   logic                  lock_meta_q, lock_meta_d;
   logic                  lock_s_q, lock_s_d;
   logic                  btn_meta_q, btn_meta_d;
   logic                  btn_s_q, btn_s_d;
   logic [CW-1:0]         deb_cnt_q, deb_cnt_d;
   logic                  btn_db_q, btn_db_d;
   logic                  btn_db_dly_q, btn_db_dly_d;

   logic                  lock_event;
   logic                  btn_event;
   logic                  any_event;
   logic [CW-1:0]         cnt_inc;

   // Input conditioning: two-flop synchronisers and button debounce
   always_comb begin
      lock_meta_d  = pll_locked;
      lock_s_d     = lock_meta_q;
      btn_meta_d   = button_n;
      btn_s_d      = btn_meta_q;
      btn_db_dly_d = btn_db_q;
      deb_cnt_d    = deb_cnt_q;
      btn_db_d     = btn_db_q;
      if (btn_s_q) begin
         deb_cnt_d = '0;
         btn_db_d  = 1'b0;
      end else if (deb_cnt_q != DEB_MAX) begin
         deb_cnt_d = deb_cnt_q + CW'(1);
         if (deb_cnt_q + CW'(1) == DEB_MAX) begin
            btn_db_d = 1'b1;
         end
      end
   end

   assign lock_event = (state_q != S_HOLD) && !lock_s_q;
   assign btn_event  = btn_db_q && !btn_db_dly_q;
   assign any_event  = lock_event || btn_event || sw_req;
   assign cnt_inc    = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      rst_d   = rst_q;
      done_d  = done_q;
      cause_d = cause_q;
      count_d = count_q;

      if (any_event) begin
         state_d = S_HOLD;
         cnt_d   = '0;
         stage_d = '0;
         rst_d   = '1;
         done_d  = 1'b0;
         if (lock_event) begin
            cause_d = CAUSE_LOCK;
         end else if (btn_event) begin
            cause_d = CAUSE_BTN;
         end else begin
            cause_d = CAUSE_SW;
         end
         // Coincident events count once; the counter sticks at 255
         if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
         end
      end else begin
         case (state_q)
            S_HOLD: begin
               rst_d = '1;
               if (lock_s_q && !btn_db_q) begin
                  if (cnt_inc == HOLD_MAX) begin
                     cnt_d   = '0;
                     rst_d   = rst_q << 1;
                     stage_d = SW'(1);
                     if (CHANNELS == 1) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                     end else begin
                        state_d = S_RELEASE;
                     end
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            S_RELEASE: begin
               if (cnt_inc == GAP_MAX) begin
                  cnt_d = '0;
                  rst_d = rst_q << 1;
                  if (stage_q == LAST_STG) begin
                     state_d = S_RUN;
                     done_d  = 1'b1;
                  end else begin
                     stage_d = stage_q + SW'(1);
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_RUN: begin
               rst_d = '0;
               cnt_d = '0;
            end
            default: begin
               state_d = S_HOLD;
               cnt_d   = '0;
               stage_d = '0;
               rst_d   = '1;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_HOLD;
         cnt_q        <= '0;
         stage_q      <= '0;
         rst_q        <= '1;
         done_q       <= 1'b0;
         cause_q      <= CAUSE_POR;
         count_q      <= 8'd0;
         lock_meta_q  <= 1'b0;
         lock_s_q     <= 1'b0;
         btn_meta_q   <= 1'b1;
         btn_s_q      <= 1'b1;
         deb_cnt_q    <= '0;
         btn_db_q     <= 1'b0;
         btn_db_dly_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stage_q      <= stage_d;
         rst_q        <= rst_d;
         done_q       <= done_d;
         cause_q      <= cause_d;
         count_q      <= count_d;
         lock_meta_q  <= lock_meta_d;
         lock_s_q     <= lock_s_d;
         btn_meta_q   <= btn_meta_d;
         btn_s_q      <= btn_s_d;
         deb_cnt_q    <= deb_cnt_d;
         btn_db_q     <= btn_db_d;
         btn_db_dly_q <= btn_db_dly_d;
      end
   end

   assign rst_out     = rst_q;
   assign done        = done_q;
   assign cause       = cause_q;
   assign reset_count = count_q;

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and run-time reset generator for the MIPSfpga board tops. It holds every downstream reset until the PLL has been locked for a programmable time. It then releases CHANNELS reset outputs one at a time in a fixed order, for example interconnect first and CPU core last. In run mode it re-enters reset on PLL lock loss, a debounced push-button press or a software request, and records the cause.

## Interface
- CHANNELS, 4: number of reset outputs, 1..16.
- HOLD_CYCLES, 32: consecutive locked cycles required before the first release, >=1.
- STAGE_GAP, 16: cycles between releases of consecutive channels, >=1.
- DEBOUNCE_CYCLES, 1024: consecutive low samples required to register a button press, >=1.

- clk  in  1  system clock (PLL output).
- reset_n  in  1  asynchronous active-low reset; puts the block in its power-on state.
- pll_locked  in  1  PLL lock, asynchronous to clk.
- button_n  in  1  board key, active-low, asynchronous and bouncing.
- sw_req  in  1  synchronous single-cycle reset request, active-high.
- rst_out  out  CHANNELS  active-high reset per channel; bit 0 is released first.
- done  out  1  high while all channels are released (state RUN).
- cause  out  2  cause of the last reset: 00 power-on, 01 lock loss, 10 button, 11 software.
- reset_count  out  8  number of non-power-on resets, saturating at 255.

## Operation
- While reset_n is low, outputs are: rst_out all ones, done 0, cause 00, reset_count 0. Internal reset values:
  - state HOLD, all counters 0.
  - lock synchroniser 0, button synchroniser 1, debounced button 0.
- Input conditioning:
  - pll_locked and button_n each pass through a 2-flop synchroniser, giving lock_s and btn_s.
  - The debounce counter increments on every edge where btn_s=0 and clears on any edge where btn_s=1.
  - btn_db is set on the edge where the debounce count reaches DEBOUNCE_CYCLES. It clears on the first edge where btn_s=1.
  - sw_req is used directly, with no synchroniser.
- Events, in priority order, each recorded in cause:
  - lock loss: lock_s=0 while in RELEASE or RUN → 01.
  - button: rising edge of btn_db → 10.
  - software: sw_req=1 → 11.
- HOLD state:
  - rst_out is all ones.
  - The counter increments on each edge with lock_s=1 and btn_db=0. Otherwise it is held at 0.
  - The edge on which the counter would reach HOLD_CYCLES moves the FSM to RELEASE, clears rst_out[0], sets stage to 1 and clears the counter.
  - A button or software event in HOLD clears the counter and updates cause and reset_count.
- RELEASE state: every STAGE_GAP edges, clear rst_out[stage] and increment stage. The edge that clears rst_out[CHANNELS-1] also enters RUN and sets done=1.
- RUN state: hold rst_out at all zeros.
- Any event in RELEASE or RUN, on the same edge:
  - state becomes HOLD, rst_out becomes all ones, done becomes 0;
  - counter and stage clear, cause is updated, reset_count increments (saturating).
- Several events on one edge: cause takes the highest-priority event and reset_count increments by 1 only.
- Button held down: the FSM stays in HOLD until btn_db clears, then counts HOLD_CYCLES again.
- CHANNELS=1: the HOLD→RELEASE edge also enters RUN and sets done.
- Counter width: $clog2(max(HOLD_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES)+1). Counters never wrap.
- Deasserting reset_n mid-sequence restarts from the power-on state; cause returns to 00.

## Timing
- All outputs are registered; no combinational path runs from inputs to outputs.
- Edges are numbered from the first rising edge after reset_n goes high, as edge 1.
- Power-up with pll_locked stable high:
  - lock_s=1 after edge 2;
  - rst_out[k] falls at edge 2+HOLD_CYCLES+k·STAGE_GAP;
  - done rises together with the fall of rst_out[CHANNELS-1].
  - With default parameters: edges 34, 50, 66 and 82.
- Lock loss: pll_locked falling before edge E gives rst_out all ones after edge E+2, i.e. 2 edges of synchroniser latency plus the FSM edge.
- Button: button_n held low from before edge E sets btn_db at edge E+1+DEBOUNCE_CYCLES; rst_out rises at edge E+2+DEBOUNCE_CYCLES.
- sw_req high at edge E gives rst_out all ones after edge E.
- After any run-time event, the release schedule repeats relative to the first counting edge in HOLD.

## Test plan
- Power-up, defaults, lock already high → rst_out bits fall at edges 34, 50, 66 and 82; done=1 at edge 82; cause=00; reset_count=0.
- Lock delayed: pll_locked rises at edge 10, drops for 3 cycles at edge 20, then returns → the HOLD counter restarts and rst_out[0] falls 32 counting edges after the final return of lock_s.
- In RUN, 1-cycle sw_req → rst_out=4'hF on the next edge; cause=11; reset_count=1; full release sequence repeats.
- DEBOUNCE_CYCLES=8, button bouncing with low pulses of 5 cycles → no reset. Button held low for 20 cycles → reset asserted at press+10 and held until release, then 32+48 cycles to done; cause=10.
- sw_req and lock loss on the same edge in RUN → cause=01 and reset_count increments by exactly 1. 300 software resets → reset_count saturates at 255.
- reset_n pulsed low during RELEASE → rst_out all ones immediately (asynchronous); cause=00; reset_count=0; power-up timing repeats.
